// File: rtl/vic_reg_bus.sv
// VIC-II CPU register responder: commits 6510 accesses on the synchronised phi0
// falling edge, holds control/raster/IRQ/colour registers and drives IRQ back.
module vic_reg_bus #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       phi0,
    input  logic       cs,
    input  logic       rw,
    input  logic [5:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [8:0] raster,
    input  logic [7:0] coll_ss,
    input  logic [7:0] coll_sb,
    output logic [6:0] o_ctrl1,
    output logic [7:0] o_ctrl2,
    output logic [7:0] o_memptr,
    output logic [3:0] o_border,
    output logic [3:0] o_bg0,
    output logic       o_irq_n
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;
    logic                   fe;

    logic [6:0] ctrl1_q,  ctrl1_d;
    logic [8:0] cmp_q,    cmp_d;
    logic [7:0] ctrl2_q,  ctrl2_d;
    logic [7:0] memptr_q, memptr_d;
    logic [2:0] irr_q,    irr_d;
    logic [3:0] imr_q,    imr_d;
    logic [7:0] css_q,    css_d;
    logic [7:0] csb_q,    csb_d;
    logic [3:0] color_q [16];
    logic [3:0] color_d [16];
    logic       match_q,  match;
    logic       irq_n_q,  irq_n_d;
    logic [7:0] dout_q,   rd_data;

    logic       wr_commit, rd_commit, is_color, irq;
    logic [2:0] irr_clr, irr_set;

    assign fe        = sync_prev_q & ~sync_q[SYNC_STAGES-1];
    assign wr_commit = fe & cs & ~rw;
    assign rd_commit = fe & cs & rw;
    assign is_color  = (addr[5:4] == 2'b10) && (addr[3:0] != 4'hF);
    assign match     = (raster == cmp_q);
    assign irq       = |({1'b0, irr_q} & imr_q);

    always_comb begin
        ctrl1_d  = ctrl1_q;
        cmp_d    = cmp_q;
        ctrl2_d  = ctrl2_q;
        memptr_d = memptr_q;
        imr_d    = imr_q;
        color_d  = color_q;
        irr_clr  = '0;
        if (wr_commit) begin
            case (addr)
                6'h11: begin
                    ctrl1_d  = din[6:0];
                    cmp_d[8] = din[7];
                end
                6'h12: cmp_d[7:0] = din;
                6'h16: ctrl2_d    = din;
                6'h18: memptr_d   = din;
                6'h19: irr_clr    = din[2:0];
                6'h1A: imr_d      = din[3:0];
                default: begin
                    if (is_color) color_d[addr[3:0]] = din[3:0];
                end
            endcase
        end
        // A read-clear in the same clk as a pulse leaves exactly the new pulse bits
        css_d = (rd_commit && addr == 6'h1E) ? coll_ss : (css_q | coll_ss);
        csb_d = (rd_commit && addr == 6'h1F) ? coll_sb : (csb_q | coll_sb);
        irr_set = {(css_q == 8'h00) && (css_d != 8'h00),
                   (csb_q == 8'h00) && (csb_d != 8'h00),
                   match & ~match_q};
        irr_d   = (irr_q & ~irr_clr) | irr_set;
        irq_n_d = ~irq;
    end

    always_comb begin
        rd_data = 8'hFF;
        case (addr)
            6'h11: rd_data = {raster[8], ctrl1_q};
            6'h12: rd_data = raster[7:0];
            6'h16: rd_data = ctrl2_q;
            6'h18: rd_data = memptr_q;
            6'h19: rd_data = {irq, 3'b111, 1'b0, irr_q};
            6'h1A: rd_data = {4'hF, imr_q};
            6'h1E: rd_data = css_q;
            6'h1F: rd_data = csb_q;
            default: begin
                if (is_color) rd_data = {4'hF, color_q[addr[3:0]]};
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
            ctrl1_q     <= '0;
            cmp_q       <= '0;
            ctrl2_q     <= '0;
            memptr_q    <= '0;
            irr_q       <= '0;
            imr_q       <= '0;
            css_q       <= '0;
            csb_q       <= '0;
            color_q     <= '{default: '0};
            match_q     <= 1'b0;
            irq_n_q     <= 1'b1;
            dout_q      <= 8'hFF;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], phi0};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
            ctrl1_q     <= ctrl1_d;
            cmp_q       <= cmp_d;
            ctrl2_q     <= ctrl2_d;
            memptr_q    <= memptr_d;
            irr_q       <= irr_d;
            imr_q       <= imr_d;
            css_q       <= css_d;
            csb_q       <= csb_d;
            color_q     <= color_d;
            match_q     <= match;
            irq_n_q     <= irq_n_d;
            if (cs && rw) dout_q <= rd_data;
        end
    end

    assign dout     = dout_q;
    assign o_ctrl1  = ctrl1_q;
    assign o_ctrl2  = ctrl2_q;
    assign o_memptr = memptr_q;
    assign o_border = color_q[0];
    assign o_bg0    = color_q[1];
    assign o_irq_n  = irq_n_q;

endmodule
